// File: rtl/fft8_in_s2p.sv
// Serial-to-parallel input stage for fft8: gathers up to 8 complex samples per frame,
// zero-pads short frames, and presents the frame on x0..x7 with a one-cycle fft_en.
module fft8_in_s2p #(
  parameter int unsigned DW = 24,
  parameter int unsigned CW = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 din_sof,
  input  logic                 din_last,
  input  logic signed [DW-1:0] din_real,
  input  logic signed [DW-1:0] din_imag,
  output logic                 fft_en,
  output logic signed [DW-1:0] x0_real,
  output logic signed [DW-1:0] x1_real,
  output logic signed [DW-1:0] x2_real,
  output logic signed [DW-1:0] x3_real,
  output logic signed [DW-1:0] x4_real,
  output logic signed [DW-1:0] x5_real,
  output logic signed [DW-1:0] x6_real,
  output logic signed [DW-1:0] x7_real,
  output logic signed [DW-1:0] x0_imag,
  output logic signed [DW-1:0] x1_imag,
  output logic signed [DW-1:0] x2_imag,
  output logic signed [DW-1:0] x3_imag,
  output logic signed [DW-1:0] x4_imag,
  output logic signed [DW-1:0] x5_imag,
  output logic signed [DW-1:0] x6_imag,
  output logic signed [DW-1:0] x7_imag,
  output logic                 drop_err,
  output logic [CW-1:0]        frame_cnt
);

  localparam int unsigned NPT = 8;
  localparam int unsigned SW  = 3;

  typedef enum logic {FILL = 1'b0, PAD = 1'b1} state_t;

  state_t               state;
  logic [SW-1:0]        cnt;
  logic signed [DW-1:0] slot_re [NPT];
  logic signed [DW-1:0] slot_im [NPT];
  logic signed [DW-1:0] x_re    [NPT];
  logic signed [DW-1:0] x_im    [NPT];

  logic                 accept_c;
  logic                 resync_c;
  logic                 wr_en_c;
  logic [SW-1:0]        wr_idx_c;
  logic signed [DW-1:0] wr_re_c;
  logic signed [DW-1:0] wr_im_c;
  logic                 done_c;

  // Slot write decode: an accepted sample in FILL, or a zero pad in PAD; sof forces slot 0.
  always_comb begin
    accept_c = (state == FILL) && din_valid && din_ready;
    resync_c = accept_c && din_sof && (cnt != '0);
    wr_en_c  = accept_c || (state == PAD);
    wr_idx_c = (accept_c && din_sof) ? '0 : cnt;
    wr_re_c  = '0;
    wr_im_c  = '0;
    if (accept_c) begin
      wr_re_c = din_real;
      wr_im_c = din_imag;
    end
    done_c = wr_en_c && (wr_idx_c == SW'(NPT - 1));
  end

  // Collect slots are always fully written before being read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      slot_re[wr_idx_c] <= wr_re_c;
      slot_im[wr_idx_c] <= wr_im_c;
    end
  end

  // Control FSM plus output frame registers; slot 7 bypasses straight into x7.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= FILL;
      cnt       <= '0;
      din_ready <= 1'b0;
      fft_en    <= 1'b0;
      drop_err  <= 1'b0;
      frame_cnt <= '0;
      for (int k = 0; k < NPT; k++) begin
        x_re[k] <= '0;
        x_im[k] <= '0;
      end
    end else begin
      fft_en   <= done_c;
      drop_err <= resync_c;
      case (state)
        FILL: begin
          din_ready <= 1'b1;
          if (accept_c) begin
            if (done_c) begin
              cnt <= '0;
            end else begin
              cnt <= wr_idx_c + SW'(1);
              if (din_last) begin
                state     <= PAD;
                din_ready <= 1'b0;
              end
            end
          end
        end
        PAD: begin
          if (done_c) begin
            cnt       <= '0;
            state     <= FILL;
            din_ready <= 1'b1;
          end else begin
            cnt <= cnt + SW'(1);
          end
        end
        default: state <= FILL;
      endcase
      if (done_c) begin
        frame_cnt <= frame_cnt + CW'(1);
        for (int k = 0; k < NPT - 1; k++) begin
          x_re[k] <= slot_re[k];
          x_im[k] <= slot_im[k];
        end
        x_re[NPT-1] <= wr_re_c;
        x_im[NPT-1] <= wr_im_c;
      end
    end
  end

  assign x0_real = x_re[0];
  assign x1_real = x_re[1];
  assign x2_real = x_re[2];
  assign x3_real = x_re[3];
  assign x4_real = x_re[4];
  assign x5_real = x_re[5];
  assign x6_real = x_re[6];
  assign x7_real = x_re[7];
  assign x0_imag = x_im[0];
  assign x1_imag = x_im[1];
  assign x2_imag = x_im[2];
  assign x3_imag = x_im[3];
  assign x4_imag = x_im[4];
  assign x5_imag = x_im[5];
  assign x6_imag = x_im[6];
  assign x7_imag = x_im[7];

endmodule
